time_pulse_sequencer: RTL and testbench

//  Sequences the AGC memory cycle on top of the timer block: counts CT edges into the
//  one-hot time pulses T01..T12 and drives the timer's STOP input. Owns the run/stop/standby

---
 rtl/agc_timing_pkg.sv | 7 +
 rtl/time_pulse_sequencer_if.sv | 15 +
 rtl/agc_edge_det.sv | 13 +
 rtl/time_pulse_sequencer.sv | 67 ++++++
 tb/tb_time_pulse_sequencer.sv | 133 +++++++++++++
 5 files changed

// File: rtl/agc_timing_pkg.sv
// agc_timing_pkg: shared state encoding and time-pulse indices for the AGC timing chain
package agc_timing_pkg;
  localparam int NUM_TP_DEF = 12;
  localparam int T01 = 0;
  localparam int T12 = NUM_TP_DEF - 1;
  typedef enum logic [1:0] {POWERON, RUN, STOPPED, STANDBY} tps_state_e;
endpackage

// File: rtl/time_pulse_sequencer_if.sv
// time_pulse_sequencer_if: timer/monitor inputs and time-pulse outputs of the sequencer
interface time_pulse_sequencer_if import agc_timing_pkg::*; #(parameter int NUM_TP = NUM_TP_DEF);
  logic CT;
  logic SBY;
  logic MSTP;
  logic MSTRT;
  logic GOJAM;
  logic [NUM_TP-1:0] T;
  logic MCT;
  logic STOP;
  logic STBY_STAT;
  logic TPZERO;
  modport master(output CT, SBY, MSTP, MSTRT, GOJAM, input T, MCT, STOP, STBY_STAT, TPZERO);
  modport slave(input CT, SBY, MSTP, MSTRT, GOJAM, output T, MCT, STOP, STBY_STAT, TPZERO);
endinterface

// File: rtl/agc_edge_det.sv
// agc_edge_det: registered rising-edge detector
module agc_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 1'b0;
    else q <= d;
  assign rise = d & ~q;
endmodule

// File: rtl/time_pulse_sequencer.sv
// time_pulse_sequencer: counts CT ticks into one-hot T01..T12 and owns run/stop/standby policy
module time_pulse_sequencer import agc_timing_pkg::*; #(
  parameter int NUM_TP     = NUM_TP_DEF,
  parameter int POWERON_CT = 8
) (
  input logic CLOCK,
  input logic SIM_RST_n,
  time_pulse_sequencer_if.slave bus
);
  localparam int CW = $clog2(POWERON_CT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(POWERON_CT - 1);
  localparam logic [NUM_TP-1:0] T_FIRST = NUM_TP'(1) << T01;
  tps_state_e state;
  logic [NUM_TP-1:0] t;
  logic [CW-1:0] cnt;
  logic mct, ct_rise, mstrt_rise, wrap;
  agc_edge_det u_ct (.clk(CLOCK), .rst_n(SIM_RST_n), .d(bus.CT), .rise(ct_rise));
  agc_edge_det u_mstrt (.clk(CLOCK), .rst_n(SIM_RST_n), .d(bus.MSTRT), .rise(mstrt_rise));
  assign wrap = state == RUN && ct_rise && t[NUM_TP-1];
  // a completed cycle reports MCT even when GOJAM wins the same edge
  always_ff @(posedge CLOCK or negedge SIM_RST_n)
    if (!SIM_RST_n) begin
      state <= POWERON;
      t <= '0;
      cnt <= '0;
      mct <= 1'b0;
    end else begin
      mct <= wrap;
      if (bus.GOJAM && state != STANDBY) begin
        state <= POWERON;
        t <= '0;
        cnt <= '0;
      end else
        case (state)
          POWERON:
            if (ct_rise) begin
              if (cnt == CNT_LAST) begin
                state <= RUN;
                t <= T_FIRST;
                cnt <= '0;
              end else cnt <= cnt + 1'b1;
            end
          RUN:
            if (wrap) begin
              state <= bus.SBY ? STANDBY : bus.MSTP ? STOPPED : RUN;
              t <= (bus.SBY || bus.MSTP) ? '0 : T_FIRST;
            end else if (ct_rise) t <= (t == '0) ? T_FIRST : t << 1;
          STOPPED:
            if (bus.SBY) state <= STANDBY;
            else if (mstrt_rise) state <= RUN;
            else if (ct_rise && !bus.MSTP) begin
              state <= RUN;
              t <= T_FIRST;
            end
          default:
            if (!bus.SBY) begin
              state <= POWERON;
              cnt <= '0;
            end
        endcase
    end
  assign bus.T = t;
  assign bus.MCT = mct;
  assign bus.STOP = state != RUN;
  assign bus.STBY_STAT = state == STANDBY;
  assign bus.TPZERO = ~|t;
endmodule

// File: tb/tb_time_pulse_sequencer.sv
// tb_time_pulse_sequencer: directed scenarios plus random stimulus against a pulse-index model
module tb_time_pulse_sequencer;
  localparam int S_PON = 0, S_RUN = 1, S_STP = 2, S_SBY = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0, n_bad = 0, mct_seen = 0;
  int m_st = S_PON, m_tp = 0, m_cnt = 0;
  bit m_mct = 0, m_ctp = 0, m_msp = 0;
  bit ct_auto = 1;
  logic [2:0] ct_div = '0;
  time_pulse_sequencer_if #(.NUM_TP(12)) bus ();
  time_pulse_sequencer #(.NUM_TP(12), .POWERON_CT(8)) dut (.CLOCK(clk), .SIM_RST_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask
  function automatic logic [31:0] exp_t();
    return m_tp == 0 ? 32'd0 : 32'd1 << (m_tp - 1);
  endfunction
  task automatic model_step();
    bit tick, srise, wrap;
    tick = bus.CT && !m_ctp;
    srise = bus.MSTRT && !m_msp;
    m_ctp = bus.CT;
    m_msp = bus.MSTRT;
    wrap = m_st == S_RUN && tick && m_tp == 12;
    m_mct = wrap;
    if (bus.GOJAM && m_st != S_SBY) begin
      m_st = S_PON; m_tp = 0; m_cnt = 0;
    end else if (m_st == S_PON) begin
      if (tick) begin
        m_cnt++;
        if (m_cnt == 8) begin m_st = S_RUN; m_tp = 1; m_cnt = 0; end
      end
    end else if (m_st == S_RUN) begin
      if (wrap) begin
        if (bus.SBY) begin m_st = S_SBY; m_tp = 0; end
        else if (bus.MSTP) begin m_st = S_STP; m_tp = 0; end
        else m_tp = 1;
      end else if (tick) m_tp = m_tp + 1;
    end else if (m_st == S_STP) begin
      if (bus.SBY) m_st = S_SBY;
      else if (srise) m_st = S_RUN;
      else if (tick && !bus.MSTP) begin m_st = S_RUN; m_tp = 1; end
    end else if (!bus.SBY) begin
      m_st = S_PON; m_cnt = 0;
    end
  endtask
  task automatic step();
    if (ct_auto) begin bus.CT = ct_div[2]; ct_div++; end
    @(posedge clk);
    model_step();
    #1;
    check("T", 32'(bus.T), exp_t());
    check("MCT", 32'(bus.MCT), 32'(m_mct));
    check("STOP", 32'(bus.STOP), 32'(m_st != S_RUN));
    check("STBY_STAT", 32'(bus.STBY_STAT), 32'(m_st == S_SBY));
    check("TPZERO", 32'(bus.TPZERO), 32'(m_tp == 0));
    if (bus.MCT) mct_seen++;
  endtask
  task automatic wait_tp(input int k);
    int n = 0;
    do begin step(); n++; end while (m_tp != k && n < 600);
    if (m_tp != k) check("timeout_tp", 32'(m_tp), 32'(k));
  endtask
  task automatic wait_st(input int s);
    int n = 0;
    do begin step(); n++; end while (m_st != s && n < 600);
    if (m_st != s) check("timeout_state", 32'(m_st), 32'(s));
  endtask
  initial begin
    bus.CT = 0; bus.SBY = 0; bus.MSTP = 0; bus.MSTRT = 0; bus.GOJAM = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_T", 32'(bus.T), 0);
    check("rst_STOP", 32'(bus.STOP), 1);
    check("rst_TPZERO", 32'(bus.TPZERO), 1);
    check("rst_STBY", 32'(bus.STBY_STAT), 0);
    check("rst_MCT", 32'(bus.MCT), 0);
    rst_n = 1;
    wait_tp(1);
    check("first_T01", 32'(bus.T), 32'h001);
    mct_seen = 0;
    repeat (288) step();
    check("free_run_mct", 32'(mct_seen), 3);
    wait_tp(5);
    bus.MSTP = 1;
    mct_seen = 0;
    wait_st(S_STP);
    check("mstp_mct", 32'(mct_seen), 1);
    check("mstp_stop", 32'(bus.STOP), 1);
    repeat (20) step();
    mct_seen = 0;
    bus.MSTRT = 1; step(); step(); bus.MSTRT = 0;
    wait_tp(6);
    bus.MSTRT = 1; step(); bus.MSTRT = 0;
    wait_st(S_STP);
    check("single_step_mct", 32'(mct_seen), 1);
    bus.MSTP = 0;
    wait_tp(3);
    bus.SBY = 1;
    wait_st(S_SBY);
    check("sby_stat", 32'(bus.STBY_STAT), 1);
    repeat (20) step();
    bus.SBY = 0;
    wait_tp(1);
    wait_tp(7);
    bus.GOJAM = 1; step(); bus.GOJAM = 0;
    check("gojam_T", 32'(bus.T), 0);
    check("gojam_STOP", 32'(bus.STOP), 1);
    wait_tp(1);
    bus.SBY = 1;
    wait_st(S_SBY);
    bus.GOJAM = 1; repeat (10) step(); bus.GOJAM = 0;
    check("gojam_in_sby", 32'(bus.STBY_STAT), 1);
    bus.SBY = 0;
    ct_auto = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) bus.CT = ~bus.CT;
      if ($urandom_range(0, 299) == 0) bus.SBY = ~bus.SBY;
      if ($urandom_range(0, 149) == 0) bus.MSTP = ~bus.MSTP;
      bus.MSTRT = $urandom_range(0, 39) == 0;
      bus.GOJAM = $urandom_range(0, 199) == 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
